// File: rtl/calc_pkg.sv
// Shared types and constants for the BCD display path: digit count, display FSM
// states and active-high 7-segment patterns (bit order gfedcba, bit0 = a).
package calc_pkg;

  localparam int unsigned NUM_DIGITOS = 5;

  typedef enum logic {ESPERA, MOSTRAR} estado_display_t;

  localparam logic [6:0] SEG_0       = 7'h3F;
  localparam logic [6:0] SEG_1       = 7'h06;
  localparam logic [6:0] SEG_2       = 7'h5B;
  localparam logic [6:0] SEG_3       = 7'h4F;
  localparam logic [6:0] SEG_4       = 7'h66;
  localparam logic [6:0] SEG_5       = 7'h6D;
  localparam logic [6:0] SEG_6       = 7'h7D;
  localparam logic [6:0] SEG_7       = 7'h07;
  localparam logic [6:0] SEG_8       = 7'h7F;
  localparam logic [6:0] SEG_9       = 7'h6F;
  localparam logic [6:0] SEG_GUION   = 7'h40;
  localparam logic [6:0] SEG_APAGADO = 7'h00;

  // Index of the highest nonzero nibble; 0 when the whole value is zero.
  function automatic logic [2:0] digito_mas_alto(input logic [4*NUM_DIGITOS-1:0] v);
    logic [2:0] h;
    h = '0;
    for (int unsigned i = 0; i < NUM_DIGITOS; i++) begin
      if (v[4*i +: 4] != 4'h0) h = 3'(i);
    end
    return h;
  endfunction

endpackage

// File: rtl/bcd_a_7seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; non-BCD codes show a dash.
module bcd_a_7seg
  import calc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_GUION;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_GUION;
    endcase
  end

endmodule

// File: rtl/display_7seg_mux.sv
// Five-digit multiplexed 7-segment driver: latches packed BCD on cargar, scans digits
// with leading-zero and anti-ghosting blanking, and drives registered pin outputs.
module display_7seg_mux
  import calc_pkg::*;
#(
  parameter int DIV_REFRESH       = 25000,
  parameter int CICLOS_BLANCO     = 250,
  parameter int ANODO_ACTIVO_BAJO = 1,
  parameter int SEG_ACTIVO_BAJO   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cargar,
  input  logic [19:0] bcd_entrada,
  input  logic        apagar,
  output logic [4:0]  anodos,
  output logic [6:0]  segmentos,
  output logic        mostrando
);

  localparam int CW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(DIV_REFRESH - 1);
  localparam logic [CW-1:0] CNT_BLANCO = CW'(CICLOS_BLANCO);
  localparam logic [2:0]    IDX_MAX    = 3'(NUM_DIGITOS - 1);
  // Inactive levels double as XOR masks to convert active-high patterns to pin polarity.
  localparam logic [4:0]    AN_OFF     = (ANODO_ACTIVO_BAJO != 0) ? 5'h1F : 5'h00;
  localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVO_BAJO != 0) ? ~SEG_APAGADO : SEG_APAGADO;

  estado_display_t estado;
  logic [19:0]     valor;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;

  logic [3:0] nibble;
  logic [6:0] seg_hi;
  logic [4:0] an_hi;
  logic [2:0] alto;
  logic       visible;

  always_comb begin
    nibble = valor[3:0];
    case (idx)
      3'd0:    nibble = valor[3:0];
      3'd1:    nibble = valor[7:4];
      3'd2:    nibble = valor[11:8];
      3'd3:    nibble = valor[15:12];
      3'd4:    nibble = valor[19:16];
      default: nibble = valor[3:0];
    endcase
  end

  bcd_a_7seg u_decod (
    .nibble (nibble),
    .seg    (seg_hi)
  );

  always_comb begin
    alto    = digito_mas_alto(valor);
    visible = (cnt >= CNT_BLANCO) && (idx <= alto);
    an_hi   = visible ? (5'b00001 << idx) : 5'b00000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= ESPERA;
      valor     <= '0;
      idx       <= '0;
      cnt       <= '0;
      anodos    <= AN_OFF;
      segmentos <= SEG_OFF;
      mostrando <= 1'b0;
    end else begin
      if (estado == MOSTRAR) begin
        anodos    <= an_hi ^ AN_OFF;
        segmentos <= seg_hi ^ SEG_OFF;
        mostrando <= 1'b1;
      end else begin
        anodos    <= AN_OFF;
        segmentos <= SEG_OFF;
        mostrando <= 1'b0;
      end

      case (estado)
        ESPERA: begin
          idx <= '0;
          cnt <= '0;
          if (cargar && !apagar) begin
            valor  <= bcd_entrada;
            estado <= MOSTRAR;
          end
        end
        MOSTRAR: begin
          if (apagar) begin
            estado <= ESPERA;
            idx    <= '0;
            cnt    <= '0;
          end else begin
            // Reloading keeps the scan position so the refresh cadence never stalls.
            if (cargar) valor <= bcd_entrada;
            if (cnt == CNT_MAX) begin
              cnt <= '0;
              idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

endmodule

// File: tb/tb_display_7seg_mux.sv
// Directed plus randomized bench for display_7seg_mux against a frame-position reference model.
module tb_display_7seg_mux;

  localparam int DIV   = 4;
  localparam int CB    = 1;
  localparam int FRAME = 5 * DIV;

  logic        clk;
  logic        rst_n;
  logic        cargar;
  logic        apagar;
  logic [19:0] bcd_entrada;
  logic [4:0]  anodos;
  logic [6:0]  segmentos;
  logic        mostrando;

  int errors;
  int checks;

  // Reference model: displaying flag, latched value, position within a 20-cycle frame.
  bit          m_show;
  logic [19:0] m_val;
  int          m_pos;
  int          act[5];

  logic [6:0] low_code [16];

  display_7seg_mux #(
    .DIV_REFRESH       (DIV),
    .CICLOS_BLANCO     (CB),
    .ANODO_ACTIVO_BAJO (1),
    .SEG_ACTIVO_BAJO   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cargar      (cargar),
    .bcd_entrada (bcd_entrada),
    .apagar      (apagar),
    .anodos      (anodos),
    .segmentos   (segmentos),
    .mostrando   (mostrando)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_show = 1'b0;
    m_val  = '0;
    m_pos  = 0;
  endtask

  task automatic clear_act();
    for (int d = 0; d < 5; d++) act[d] = 0;
  endtask

  // Drive inputs at a falling edge, model the rising edge, check at the next falling edge.
  task automatic tick(input logic c, input logic a, input logic [19:0] b);
    logic [4:0] e_an;
    logic [6:0] e_seg;
    logic       e_mo;
    int         d, s, h, nib, on;
    cargar      = c;
    apagar      = a;
    bcd_entrada = b;
    @(posedge clk);
    if (!m_show) begin
      e_an = 5'h1F; e_seg = 7'h7F; e_mo = 1'b0;
    end else begin
      d = m_pos / DIV;
      s = m_pos % DIV;
      h = 0;
      for (int k = 0; k < 5; k++) if (((m_val >> (4*k)) & 20'hF) != 0) h = k;
      nib   = int'((m_val >> (4*d)) & 20'hF);
      e_seg = low_code[nib];
      e_an  = (s >= CB && d <= h) ? ~(5'b00001 << d) : 5'h1F;
      e_mo  = 1'b1;
    end
    if (a) begin
      m_show = 1'b0;
      m_pos  = 0;
    end else if (!m_show) begin
      if (c) begin
        m_show = 1'b1;
        m_val  = b;
        m_pos  = 0;
      end
    end else begin
      if (c) m_val = b;
      m_pos = (m_pos + 1) % FRAME;
    end
    @(negedge clk);
    cargar = 1'b0;
    apagar = 1'b0;
    chk("anodos", 20'(anodos), 20'(e_an));
    chk("segmentos", 20'(segmentos), 20'(e_seg));
    chk("mostrando", 20'(mostrando), 20'(e_mo));
    on = 0;
    for (int k = 0; k < 5; k++) if (anodos[k] == 1'b0) begin on++; act[k]++; end
    checks++;
    assert (on <= 1) else begin
      errors++;
      $error("FAIL one_hot observed=%0d active anodes expected<=1", on);
    end
  endtask

  task automatic chk_act(input string tag, input int e0, input int e1, input int e2,
                         input int e3, input int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    for (int k = 0; k < 5; k++) begin
      checks++;
      assert (act[k] == e[k]) else begin
        errors++;
        $error("FAIL %s digit%0d active cycles observed=%0d expected=%0d", tag, k, act[k], e[k]);
      end
    end
  endtask

  initial begin
    logic [19:0] rv;
    errors = 0;
    checks = 0;
    low_code = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    model_reset();
    clear_act();
    rst_n = 1'b0; cargar = 1'b0; apagar = 1'b0; bcd_entrada = '0;

    // 1. Reset values, idle after release, asynchronous reset mid-scan.
    repeat (3) @(negedge clk);
    chk("rst_anodos", 20'(anodos), 20'h1F);
    chk("rst_segmentos", 20'(segmentos), 20'h7F);
    chk("rst_mostrando", 20'(mostrando), 20'h0);
    rst_n = 1'b1;
    repeat (40) tick(1'b0, 1'b0, 20'h12345);
    tick(1'b1, 1'b0, 20'h00255);
    repeat (9) tick(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_anodos", 20'(anodos), 20'h1F);
    chk("async_segmentos", 20'(segmentos), 20'h7F);
    chk("async_mostrando", 20'(mostrando), 20'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 2. 00255: digits 0..2 active 3 cycles per frame, 3 and 4 never.
    tick(1'b1, 1'b0, 20'h00255);
    tick(1'b0, 1'b0, '0);
    clear_act();
    repeat (FRAME) tick(1'b0, 1'b0, '0);
    chk_act("frame_00255", 3, 3, 3, 0, 0);

    // 3. Zero value: only digit 0 lit.
    tick(1'b1, 1'b0, 20'h00000);
    tick(1'b0, 1'b0, '0);
    clear_act();
    repeat (FRAME) tick(1'b0, 1'b0, '0);
    chk_act("frame_zero", 3, 0, 0, 0, 0);

    // 4. Inner zeros shown, invalid nibble as dash.
    tick(1'b1, 1'b0, 20'h1A003);
    tick(1'b0, 1'b0, '0);
    clear_act();
    repeat (FRAME) tick(1'b0, 1'b0, '0);
    chk_act("frame_1A003", 3, 3, 3, 3, 3);

    // 5. Reload mid-slot keeps scan position.
    tick(1'b1, 1'b0, 20'h00255);
    repeat (6) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 20'h00009);
    tick(1'b0, 1'b0, '0);
    clear_act();
    repeat (FRAME) tick(1'b0, 1'b0, '0);
    chk_act("frame_reload", 3, 0, 0, 0, 0);

    // 6. cargar with apagar: apagar wins; later cargar restarts at digit 0.
    repeat (3) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, 20'h88888);
    repeat (5) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 20'h04321);
    repeat (FRAME) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b1, 20'h00007);
    tick(1'b1, 1'b1, 20'h00007);
    repeat (3) tick(1'b0, 1'b0, '0);

    // 7. Randomized traffic, including invalid nibbles and short values.
    for (int n = 0; n < 400; n++) begin
      rv = 20'($urandom);
      rv = rv >> (4 * $urandom_range(0, 4));
      tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 40) == 0), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
